fc_neuron_seq: RTL
==================

// Module: fc_neuron_seq
// PURPOSE
//  Time-multiplexed fully-connected layer slice: N_OUT neurons share one streamed input vector of IN
//  signed WIDTH-bit activations, each applying runtime-loaded signed weights, accumulating and
//  applying optional ReLU. Replaces the fully-unrolled constant-multiplier adder tree for layers too
//  large to unroll; sits between an activation buffer (upstream) and the next layer (downstream).
// PARAMETERS
//  WIDTH    8    activation/weight width, signed two's complement
//  IN       128  inputs per neuron (vector length, >=2)
//  N_OUT    4    neurons computed in parallel
//  RELU_EN  1    1: clamp negative results to 0; 0: pass signed sum
//  AW       $clog2(IN)           derived weight address width
//  ACC_W    WIDTH*2+$clog2(IN)   derived accumulator/output width per neuron
// PORTS
//  clk      in   1             single clock, rising edge
//  rst_n    in   1             asynchronous active-low reset
//  w_we     in   1             weight row write strobe
//  w_addr   in   AW            weight row index (input position)
//  w_data   in   N_OUT*WIDTH   row of weights, neuron n at [n*WIDTH +: WIDTH]
//  w_ready  out  1             weight writes accepted (high only in IDLE)
//  x_valid  in   1             input activation valid
//  x_ready  out  1             block accepts activation
//  x_data   in   WIDTH         activation, presented in order index 0..IN-1
//  z_valid  out  1             result vector valid
//  z_ready  in   1             downstream accepts result
//  z_data   out  N_OUT*ACC_W   results, neuron n at [n*ACC_W +: ACC_W]
// BEHAVIOUR
//  - Reset: state IDLE, idx=0, all accumulators 0, z_valid=0, z_data=0, x_ready=0, w_ready=1.
//    Weight memory contents are NOT reset. Reset mid-operation abandons the vector; no partial output.
//  - FSM: IDLE -> ACCUM on first x_valid (IDLE also holds x_ready=1, so that beat is consumed);
//    ACCUM -> DRAIN when beat idx==IN-1 is accepted; DRAIN -> OUT after the multiply pipe empties;
//    OUT -> IDLE on z_valid&&z_ready.
//  - Beat transfer = x_valid&&x_ready. x_ready=1 in IDLE and ACCUM only. idx increments per beat and
//    wraps to 0 after IN-1. Gaps in x_valid are legal; nothing advances without a transfer.
//  - Datapath: stage1 registers x_data*W[idx][n] (signed 2*WIDTH product, full precision);
//    stage2 sign-extends into ACC_W accumulator. First beat of a vector loads (not adds) the accumulator.
//    No overflow possible: ACC_W holds IN*(-2^(WIDTH-1))^2.
//  - Latency: z_valid rises exactly 2 cycles after the last beat's transfer edge.
//  - Output: z_data = RELU_EN && acc[ACC_W-1] ? 0 : acc, per neuron. z_valid/z_data held stable
//    until z_ready; x_ready stays 0 in OUT (backpressure). z_valid&&z_ready in the same cycle as
//    x_valid: that x beat is not accepted until the following (IDLE) cycle.
//  - Weight write: applied when w_we&&w_ready, one row per cycle; w_we while w_ready=0 is ignored
//    (no effect, no error). w_addr>=IN ignored.
// STRUCTURE
//  - Package fc_pkg: fsm state enum (IDLE, ACCUM, DRAIN, OUT), acc_w() width function.
//  - Sub-module fc_mac_lane (one per neuron, generate loop): registered multiply + accumulator +
//    ReLU; top holds FSM, idx counter, weight RAM (IN x N_OUT*WIDTH, sync write, comb read).
// TESTING (WIDTH=8, IN=4, N_OUT=2, RELU_EN=1 unless noted)
//  1 W ch0={1,2,3,4}, ch1={-1,-1,-1,-1}; x={1,1,1,1} back-to-back -> z ch0=10, ch1=0; z_valid 2 cyc after beat 3.
//  2 Same, RELU_EN=0 -> ch1 = -4 (18'h3FFFC); ch0 = 10.
//  3 All W=-128, all x=-128 -> ch0=ch1=65536, no overflow; all x=127, W=-128 -> RELU_EN=0: -65024.
//  4 Random x_valid gaps and z_ready held low 5 cycles -> same result, z_data stable, x_ready=0 while OUT.
//  5 w_we pulsed during ACCUM with garbage -> ignored; next vector uses original weights.
//  6 rst_n asserted after beat 2, then full vector {2,2,2,2} -> ch0=20, no stale partial sum.

Source files
------------

// File: rtl/fc_neuron_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed fully-connected neuron slice.
package fc_pkg;

    // Control states: wait for a vector, stream it, flush the multiply pipe, hold the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fc_state_t;

    // Accumulator width that cannot overflow for in_len products of two width-bit signed values.
    function automatic int acc_w(input int width, input int in_len);
        return 2 * width + $clog2(in_len);
    endfunction

endpackage

// File: rtl/fc_neuron_seq_mac_lane.sv
// One neuron lane: registered signed multiply, sign-extending accumulator, optional ReLU on the output.
module fc_mac_lane #(
    parameter int WIDTH   = 8,
    parameter int ACC_W   = 18,
    parameter bit RELU_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               beat,
    input  logic [WIDTH-1:0]   x_data,
    input  logic [WIDTH-1:0]   w_data,
    input  logic               acc_en,
    input  logic               acc_load,
    output logic [ACC_W-1:0]   z_data
);

    logic signed [2*WIDTH-1:0] prod_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [ACC_W-1:0]   prod_ext;

    assign prod_ext = {{(ACC_W-2*WIDTH){prod_reg[2*WIDTH-1]}}, prod_reg};

    // Stage 1: capture the full-precision product of the accepted activation and its weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
        end else if (beat) begin
            prod_reg <= $signed(x_data) * $signed(w_data);
        end
    end

    // Stage 2: the first product of a vector overwrites the accumulator, later ones add to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (acc_en) begin
            acc_reg <= acc_load ? prod_ext : acc_reg + prod_ext;
        end
    end

    assign z_data = (RELU_EN && acc_reg[ACC_W-1]) ? '0 : acc_reg;

endmodule

// File: rtl/fc_neuron_seq.sv
// Fully-connected layer slice: N_OUT neurons share one streamed activation vector and a weight RAM.
module fc_neuron_seq
    import fc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int N_OUT   = 4,
    parameter bit RELU_EN = 1'b1,
    parameter int AW      = $clog2(IN),
    parameter int ACC_W   = acc_w(WIDTH, IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_we,
    input  logic [AW-1:0]          w_addr,
    input  logic [N_OUT*WIDTH-1:0] w_data,
    output logic                   w_ready,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [WIDTH-1:0]       x_data,
    output logic                   z_valid,
    input  logic                   z_ready,
    output logic [N_OUT*ACC_W-1:0] z_data
);

    fc_state_t state_reg, state_next;
    logic [AW-1:0]          idx_reg;
    logic                   x_ready_reg;
    logic                   w_ready_reg;
    logic                   s1_valid_reg;
    logic                   s1_first_reg;
    logic                   beat;
    logic                   last_beat;
    logic [N_OUT*WIDTH-1:0] w_mem [IN];
    logic [N_OUT*WIDTH-1:0] w_row;

    assign beat      = x_valid && x_ready_reg;
    assign last_beat = beat && (idx_reg == AW'(IN - 1));
    assign x_ready   = x_ready_reg;
    assign w_ready   = w_ready_reg;
    assign z_valid   = (state_reg == OUT);
    assign w_row     = w_mem[idx_reg];

    // Next-state: DRAIN waits for the last product to reach the accumulators before presenting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (beat) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = DRAIN;
            DRAIN:   if (!s1_valid_reg) state_next = OUT;
            OUT:     if (z_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, handshake readies (registered from the next state) and the input index counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            x_ready_reg  <= 1'b0;
            w_ready_reg  <= 1'b1;
            idx_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_ready_reg  <= (state_next == IDLE) || (state_next == ACCUM);
            w_ready_reg  <= (state_next == IDLE);
            s1_valid_reg <= beat;
            s1_first_reg <= beat && (idx_reg == '0);
            if (beat) begin
                idx_reg <= (idx_reg == AW'(IN - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // Weight RAM write port: rows are only accepted while idle; out-of-range rows are dropped.
    always_ff @(posedge clk) begin
        if (w_we && w_ready_reg && (int'(w_addr) < IN)) begin
            w_mem[w_addr] <= w_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_lane
            fc_mac_lane #(
                .WIDTH   (WIDTH),
                .ACC_W   (ACC_W),
                .RELU_EN (RELU_EN)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .beat     (beat),
                .x_data   (x_data),
                .w_data   (w_row[gi*WIDTH +: WIDTH]),
                .acc_en   (s1_valid_reg),
                .acc_load (s1_first_reg),
                .z_data   (z_data[gi*ACC_W +: ACC_W])
            );
        end
    endgenerate

endmodule
